// File: rtl/count_seq_ctrl_pkg.sv
// Shared constants for the sequence-counter controller: FSM state codes
// (also shown on LEDG) and push-button bit positions.
package count_seq_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int K_STEP = 0;
    localparam int K_LOAD = 1;
    localparam int K_RUN  = 2;
    localparam int K_CLR  = 3;

endpackage

// File: rtl/key_edge_sync.sv
// Per-bit two-flop synchroniser for active-low push buttons, followed by a
// falling-edge detector that yields a single-cycle press pulse per key.
module key_edge_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] key_n_i,
    output logic [W-1:0] press_o
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] prev_q;

    // Reset to all ones so released buttons never look like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequences the 4-bit sequence counter from push buttons: load, single step,
// prescaled free-run with optional stop value, pause and done.
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int DIV_W = 26,
    parameter int DIV   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic [3:0] sw_load,
    input  logic [3:0] sw_stop,
    input  logic       stop_en,
    input  logic [3:0] cnt_q,
    output logic       cnt_load,
    output logic [3:0] cnt_load_data,
    output logic       cnt_step,
    output logic [2:0] state_o,
    output logic       run_led,
    output logic       done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [3:0]       press;
    logic             p_clr, p_load, p_run, p_step;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       load_data_q, load_data_d;
    logic             stepped_q;
    logic             stop_hit;
    logic             wrap;
    logic             load_strobe, step_strobe;

    key_edge_sync #(.W(4)) u_keys (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_n),
        .press_o (press)
    );

    // Only the highest-priority press of a cycle is acted on.
    assign p_clr  = press[K_CLR];
    assign p_load = press[K_LOAD] & ~press[K_CLR];
    assign p_run  = press[K_RUN] & ~press[K_CLR] & ~press[K_LOAD];
    assign p_step = press[K_STEP] & ~press[K_CLR] & ~press[K_LOAD] & ~press[K_RUN];

    assign stop_hit = stepped_q & stop_en & (cnt_q == sw_stop);
    assign wrap     = (presc_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        load_strobe = 1'b0;
        step_strobe = 1'b0;
        case (state_q)
            S_IDLE, S_PAUSE, S_DONE: begin
                if (p_clr)       state_d = S_IDLE;
                else if (p_load) state_d = S_LOAD;
                else if (p_run)  state_d = S_RUN;
                else if (p_step) state_d = S_STEP;
            end
            S_LOAD: begin
                load_strobe = ~p_clr;
                state_d     = p_clr ? S_IDLE : S_PAUSE;
            end
            S_STEP: begin
                step_strobe = ~p_clr;
                state_d     = p_clr ? S_IDLE : S_PAUSE;
            end
            S_RUN: begin
                // The stop check sees the counter one cycle after its step.
                if (p_clr)         state_d = S_IDLE;
                else if (stop_hit) state_d = S_DONE;
                else if (p_load)   state_d = S_LOAD;
                else if (p_run)    state_d = S_PAUSE;
                else               step_strobe = wrap;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_LOAD) begin
            load_data_d = sw_load;
        end
    end

    // Prescaler only counts while staying in RUN, so every entry starts at 0.
    always_comb begin
        presc_d = '0;
        if (state_q == S_RUN && state_d == S_RUN) begin
            presc_d = wrap ? '0 : presc_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            load_data_q <= '0;
            stepped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            load_data_q <= load_data_d;
            stepped_q   <= step_strobe;
        end
    end

    assign cnt_load      = load_strobe;
    assign cnt_step      = step_strobe;
    assign cnt_load_data = load_data_q;
    assign state_o       = state_q;
    assign run_led       = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Testbench for count_seq_ctrl: directed scenarios plus random key traffic,
// checked every cycle against a behavioural model of the controller.
module tb_count_seq_ctrl;

    localparam int DIV_W = 26;
    localparam int DIV   = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] sw_load;
    logic [3:0] sw_stop;
    logic       stop_en;
    logic [3:0] cnt_q;
    logic       cnt_load;
    logic [3:0] cnt_load_data;
    logic       cnt_step;
    logic [2:0] state_o;
    logic       run_led;
    logic       done;

    always #5 clk = ~clk;

    count_seq_ctrl #(.DIV_W(DIV_W), .DIV(DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .sw_load       (sw_load),
        .sw_stop       (sw_stop),
        .stop_en       (stop_en),
        .cnt_q         (cnt_q),
        .cnt_load      (cnt_load),
        .cnt_load_data (cnt_load_data),
        .cnt_step      (cnt_step),
        .state_o       (state_o),
        .run_led       (run_led),
        .done          (done)
    );

    // Counter datapath stand-in: loads on cnt_load, increments on cnt_step.
    always @(posedge clk) begin
        if (reset)         cnt_q <= 4'd0;
        else if (cnt_load) cnt_q <= cnt_load_data;
        else if (cnt_step) cnt_q <= cnt_q + 4'd1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // States: 0 idle, 1 load, 2 step, 3 run, 4 pause, 5 done.
    int         m_state   = 0;
    int         m_run_cyc = 0;   // cycles spent in RUN since entry
    bit         m_stepped = 1'b0;
    logic [3:0] m_data    = 4'h0;
    logic [3:0] hist[$];         // key_n samples at past edges, newest first

    int cyc           = 0;
    int n_loads       = 0;
    int n_steps       = 0;
    int last_load_cyc = -1;
    int first_step    = -1;

    task automatic model_reset();
        m_state   = 0;
        m_run_cyc = 0;
        m_stepped = 1'b0;
        m_data    = 4'h0;
        hist      = '{4'hF, 4'hF, 4'hF};
    endtask

    // One clock cycle: compare outputs at negedge, advance model across posedge.
    task automatic tick();
        logic [3:0] pr;
        bit pc, pl, prn, ps, stop, e_load, e_step;
        int nxt;
        pr  = hist[2] & ~hist[1];
        pc  = pr[3];
        pl  = pr[1] & ~pr[3];
        prn = pr[2] & ~pr[3] & ~pr[1];
        ps  = pr[0] & (pr[3:1] == 3'b000);
        stop   = (m_state == 3) && m_stepped && stop_en && (cnt_q == sw_stop);
        e_load = (m_state == 1) && !pc;
        e_step = ((m_state == 2) && !pc) ||
                 ((m_state == 3) && !pc && !stop && !pl && !prn && ((m_run_cyc % DIV) == DIV - 1));
        check_eq("state", 32'(state_o), 32'(m_state));
        check_eq("strobes", 32'({cnt_load, cnt_step, run_led, done}),
                 32'({e_load, e_step, m_state == 3, m_state == 5}));
        check_eq("load_data", 32'(cnt_load_data), 32'(m_data));
        if (cnt_load) begin
            n_loads++;
            last_load_cyc = cyc;
        end
        if (cnt_step) begin
            n_steps++;
            if (first_step < 0) first_step = cyc;
        end
        nxt = m_state;
        if (pc) nxt = 0;
        else begin
            case (m_state)
                0, 4, 5: if (pl) nxt = 1; else if (prn) nxt = 3; else if (ps) nxt = 2;
                1, 2:    nxt = 4;
                3:       if (stop) nxt = 5; else if (pl) nxt = 1; else if (prn) nxt = 4;
                default: nxt = 0;
            endcase
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (nxt == 1) m_data = sw_load;
            if (nxt == 3 && m_state == 3) m_run_cyc++;
            else                          m_run_cyc = 0;
            m_stepped = e_step;
            m_state   = nxt;
            hist.push_front(key_n);
            void'(hist.pop_back());
        end
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_key(input int k);
        key_n[k] = 1'b0;
        idle(2);
        key_n[k] = 1'b1;
    endtask

    int c0, base;
    bit found;

    initial begin
        reset   = 1'b1;
        key_n   = 4'hF;
        sw_load = 4'h0;
        sw_stop = 4'h0;
        stop_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle(2);
        reset = 1'b0;

        // Quiet after reset
        idle(20);
        check_eq("idle_loads", 32'(n_loads), 0);
        check_eq("idle_steps", 32'(n_steps), 0);

        // Load press: one strobe, three edges after the key falls
        sw_load = 4'h7;
        base = n_loads;
        c0 = cyc;
        press_key(1);
        idle(6);
        check_eq("load_count", 32'(n_loads - base), 1);
        check_eq("load_latency", 32'(last_load_cyc - c0), 3);
        check_eq("load_value", 32'(cnt_load_data), 7);
        check_eq("after_load_state", 32'(state_o), 4);

        // Held step key gives exactly one step
        base = n_steps;
        key_n[0] = 1'b0;
        idle(10);
        key_n[0] = 1'b1;
        idle(5);
        check_eq("held_step_count", 32'(n_steps - base), 1);
        check_eq("held_step_state", 32'(state_o), 4);

        // Free-run without stop: step in every 4th RUN cycle
        stop_en = 1'b0;
        base = n_steps;
        first_step = -1;
        c0 = cyc;
        press_key(2);
        idle(20);
        check_eq("run_first_step", 32'(first_step - c0), 6);
        check_eq("run_step_count", 32'(n_steps - base), 4);
        press_key(2);
        idle(8);
        check_eq("run_pause_state", 32'(state_o), 4);

        // Stop at sw_stop = 3 from a counter loaded with 0
        sw_load = 4'h0;
        press_key(1);
        idle(6);
        check_eq("cnt_zero", 32'(cnt_q), 0);
        stop_en = 1'b1;
        sw_stop = 4'h3;
        press_key(2);
        idle(30);
        check_eq("stop_state", 32'(state_o), 5);
        check_eq("stop_done", 32'(done), 1);
        check_eq("stop_cnt", 32'(cnt_q), 3);
        base = n_steps;
        idle(20);
        check_eq("done_no_steps", 32'(n_steps - base), 0);

        // Clear + load together while running: clear wins, no load
        stop_en = 1'b0;
        press_key(2);
        idle(5);
        check_eq("rerun_state", 32'(state_o), 3);
        base = n_loads;
        key_n[3] = 1'b0;
        key_n[1] = 1'b0;
        idle(2);
        key_n = 4'hF;
        idle(6);
        check_eq("clr_state", 32'(state_o), 0);
        check_eq("clr_no_load", 32'(n_loads - base), 0);

        // Reset on a prescaler-wrap cycle in RUN
        press_key(2);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cnt_step) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("wrap_found", 32'(found), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("wrap_reset_outs",
                 32'({state_o, cnt_load, cnt_step, cnt_load_data, run_led, done}), 0);
        idle(3);

        // Random key traffic and switch settings
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) key_n[b] = ~key_n[b];
            end
            if ($urandom_range(0, 15) == 0) begin
                sw_load = 4'($urandom_range(0, 15));
                sw_stop = 4'($urandom_range(0, 15));
                stop_en = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        key_n = 4'hF;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
